pwm_datapath: RTL
=================

PWM_DATAPATH -- requirements
Module: pwm_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 16, which sets the period, duty and counter width.
REQ-002 SHALL have parameter PSC_W, default 8, which sets the prescaler divide-value width.
REQ-003 Ports, clock and reset first:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have the host configuration ports:
- cfg_valid  in  1  host offers a new period/duty pair.
- cfg_period  in  WIDTH  requested period in ticks.
- cfg_duty  in  WIDTH  requested high-time in ticks.
- cfg_ready  out  1  staging slot is free.
REQ-005 SHALL have the controller-side ports:
- loadReg  in  1  idle commit strobe from the control unit.
- loadCNT  in  1  counter reload strobe from the control unit.
- isEq1  out  1  count equals active duty (low-to-high point).
- isEq0  out  1  count equals zero (end of period).
- count  out  WIDTH  current counter value, for debug.

Function
REQ-006 SHALL accept a configuration in a cycle where cfg_valid && cfg_ready, capturing cfg_period and cfg_duty into the staging registers and setting the pending flag.
REQ-007 SHALL drive cfg_ready = !pending, and SHALL ignore cfg_valid while pending is set.
REQ-008 SHALL commit staging to the active registers on any cycle with (loadReg || loadCNT) && pending, clearing pending in the same edge.
REQ-009 When accept and commit fall in the same cycle, the active registers SHALL take the previous staging contents and the new pair SHALL remain pending.
REQ-010 SHALL clamp the active duty to the active period at commit when duty > period.
REQ-011 On loadCNT, count SHALL load the active period, using the value being committed that same edge if a commit occurs.
REQ-012 Otherwise count SHALL decrement by 1 on each tick while count > 0.
REQ-013 count SHALL hold at 0 and never wrap below 0.
REQ-014 isEq1 SHALL be combinational (count == active_duty).
REQ-015 isEq0 SHALL be combinational (count == 0).
REQ-016 Zero-latency rules:
- duty == 0: isEq1 and isEq0 assert in the same cycle.
- period == 0: isEq0 asserts in the cycle after the reload.
REQ-017 loadCNT SHALL take priority over a tick in the same cycle.
REQ-018 loadReg alone SHALL NOT touch count.

Reset
REQ-019 Asynchronous reset SHALL clear the following: count, staging, active period, active duty, pending, and the prescaler.
REQ-020 Out of reset, the outputs SHALL be cfg_ready = 1, isEq0 = 1, isEq1 = 1 and count = 0.
REQ-021 Reset asserted mid-period SHALL discard the pending configuration with no commit.

Configuration
REQ-022 With PWM_PRESCALE_EN defined:
- SHALL add ports cfg_psc (in, PSC_W) and psc_active (out, PSC_W).
- cfg_psc SHALL be staged and committed together with period and duty.
- A tick SHALL occur once every psc_active+1 clocks.
- The prescaler SHALL restart on loadCNT.
REQ-023 Without PWM_PRESCALE_EN, every clock SHALL be a tick, and the prescaler ports and logic SHALL be absent.

Structure
REQ-024 The shared package pwm_pkg SHALL hold the following:
- default WIDTH and PSC_W constants.
- a cfg_t struct type {period, duty[, psc]}, used for the staging and active registers.
REQ-025 The prescaler SHALL be a separate sub-module, pwm_prescaler, with ports clk, reset, restart, div and tick.
REQ-026 pwm_datapath SHALL instantiate pwm_prescaler only under PWM_PRESCALE_EN.

Verification
REQ-027 Bench scenarios SHALL be:
- Reset then idle: cfg_ready=1, count=0, isEq0=1.
- Handshake: cfg_valid with period=10, duty=4 -> cfg_ready=0 on the next cycle. Then pulse loadReg -> active=10/4 and cfg_ready=1.
- Counting: loadCNT with period=10, duty=4 -> count 10,9,...,0. isEq1 is high only at count=4, isEq0 only at count=0. count holds at 0 with no further loadCNT.
- Boundary update: accept 6/2 mid-period, then loadCNT when isEq0 -> count=6 and active duty=2 on the same edge. Same-cycle cfg_valid with loadCNT behaves per REQ-009.
- Clamp and edge values: period=5, duty=9 -> active duty=5 and isEq1 at reload. duty=0 -> isEq1 and isEq0 coincide.
- PWM_PRESCALE_EN with psc=2, period=3 -> count decrements every 3 clocks. Reset asserted mid-count -> count=0 and pending cleared.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and the period/duty(/prescale) record used by the
// PWM datapath. Build option: PWM_PRESCALE_EN adds the prescale field.
package pwm_pkg;

   localparam int PWM_WIDTH = 16;
   localparam int PWM_PSC_W = 8;

   // One complete PWM setting; used for both the staging and active copies.
   typedef struct packed {
      logic [PWM_WIDTH-1:0] period;
      logic [PWM_WIDTH-1:0] duty;
`ifdef PWM_PRESCALE_EN
      logic [PWM_PSC_W-1:0] psc;
`endif
   } cfg_t;

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: emits one tick every div+1 clocks; restart realigns the
// window so the first tick after a reload lands div+1 clocks later.
module pwm_prescaler
   import pwm_pkg::*;
#(
   parameter int PSC_W = PWM_PSC_W
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             restart,
   input  logic [PSC_W-1:0] div,
   output logic             tick
);

   localparam logic [PSC_W-1:0] ONE = PSC_W'(1);

   logic [PSC_W-1:0] phaseReg;

   // '>=' rather than '==' so a smaller divider committed mid-window cannot
   // leave the phase stranded above it.
   assign tick = (phaseReg >= div);

   // Phase counter: cleared on restart or after each tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         phaseReg <= '0;
      else if (restart || tick)
         phaseReg <= '0;
      else
         phaseReg <= phaseReg + ONE;
   end

endmodule

// File: rtl/pwm_datapath.sv
// pwm_datapath: staged period/duty configuration, active registers and the
// down-counter that drives the PWM control unit's compare flags.
// Build option: PWM_PRESCALE_EN adds a programmable tick prescaler
// (cfg_psc / psc_active ports and the pwm_prescaler instance).
module pwm_datapath
   import pwm_pkg::*;
#(
   parameter int WIDTH = PWM_WIDTH,
   parameter int PSC_W = PWM_PSC_W
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_valid,
   input  logic [WIDTH-1:0] cfg_period,
   input  logic [WIDTH-1:0] cfg_duty,
`ifdef PWM_PRESCALE_EN
   input  logic [PSC_W-1:0] cfg_psc,
   output logic [PSC_W-1:0] psc_active,
`endif
   output logic             cfg_ready,
   input  logic             loadReg,
   input  logic             loadCNT,
   output logic             isEq1,
   output logic             isEq0,
   output logic [WIDTH-1:0] count
);

   // cfg_t is sized by the package, so the module widths must agree with it.
   if (WIDTH != PWM_WIDTH || PSC_W != PWM_PSC_W) begin : gWidthGuard
      $error("pwm_datapath: WIDTH/PSC_W must match pwm_pkg constants");
   end

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   cfg_t             stageReg;
   cfg_t             activeReg;
   cfg_t             commitVal;
   logic             pendingReg;
   logic [WIDTH-1:0] countReg;
   logic             accept;
   logic             commit;
   logic             tick;

   assign cfg_ready = !pendingReg;
   assign accept    = cfg_valid && !pendingReg;
   assign commit    = (loadReg || loadCNT) && pendingReg;

   // Value written to the active copy: staging with duty clamped to period.
   always_comb begin
      commitVal = stageReg;
      if (stageReg.duty > stageReg.period)
         commitVal.duty = stageReg.period;
   end

   // Staging slot: captures the host pair on a handshake.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stageReg <= '0;
      end else if (accept) begin
         stageReg.period <= cfg_period;
         stageReg.duty   <= cfg_duty;
`ifdef PWM_PRESCALE_EN
         stageReg.psc    <= cfg_psc;
`endif
      end
   end

   // Pending flag: a fresh accept wins over a commit of the older pair.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pendingReg <= 1'b0;
      else
         pendingReg <= accept || (pendingReg && !commit);
   end

   // Active copy: updated only at a commit strobe while a pair is pending.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         activeReg <= '0;
      else if (commit)
         activeReg <= commitVal;
   end

   // Down-counter: reload beats tick; saturates at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         countReg <= '0;
      else if (loadCNT)
         countReg <= commit ? stageReg.period : activeReg.period;
      else if (tick && (countReg != '0))
         countReg <= countReg - ONE;
   end

   assign count = countReg;
   assign isEq1 = (countReg == activeReg.duty);
   assign isEq0 = (countReg == '0);

`ifdef PWM_PRESCALE_EN
   pwm_prescaler #(
      .PSC_W   (PSC_W)
   ) uPrescaler (
      .clk     (clk),
      .reset   (reset),
      .restart (loadCNT),
      .div     (activeReg.psc),
      .tick    (tick)
   );

   assign psc_active = activeReg.psc;
`else
   assign tick = 1'b1;
`endif

endmodule
